// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types and constants for the ALU issue controller.
package alu_issue_ctrl_pkg;

  localparam int unsigned SelW = 3;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StHold
  } state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU and response signal bundle between the issue controller and its environment.
interface alu_issue_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  import alu_issue_ctrl_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [SelW-1:0]  req_sel;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [SelW-1:0]  alu_sel;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic [SelW-1:0]  rsp_sel;

  // Controller side.
  modport slave (
    input  req_valid, req_a, req_b, req_sel, alu_out, alu_zero, rsp_ready,
    output req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_zero, rsp_sel
  );

  // Requester / ALU / consumer side.
  modport master (
    output req_valid, req_a, req_b, req_sel, alu_out, alu_zero, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_zero, rsp_sel
  );

endinterface

// File: rtl/alu_issue_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one operation at a time to an external ALU, captures its result and holds it
// until the consumer takes it; counts completed and zero-result operations.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_ctrl_if.slave   bus,
  output logic [CNT_W-1:0]  op_count,
  output logic [CNT_W-1:0]  zero_count,
  output logic              busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [SelW-1:0]  alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [SelW-1:0]  rsp_sel_q, rsp_sel_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_hs;

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_sel_d   = rsp_sel_q;
    rsp_valid_d = rsp_valid_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          alu_a_d   = bus.req_a;
          alu_b_d   = bus.req_b;
          alu_sel_d = bus.req_sel;
          state_d   = StDrive;
        end
      end
      // Operands have been on the ALU for a full cycle; its result is settled here.
      StDrive: begin
        rsp_data_d  = bus.alu_out;
        rsp_zero_d  = bus.alu_zero;
        rsp_sel_d   = alu_sel_q;
        rsp_valid_d = 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_sel_q   <= rsp_sel_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_hs = (state_q == StHold) && bus.rsp_ready;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_op_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rsp_hs),
    .count (op_count)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_zero_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rsp_hs && rsp_zero_q),
    .count (zero_count)
  );

  assign bus.req_ready = (state_q == StIdle);
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_sel   = rsp_sel_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand/result width.
REQ-002 The module SHALL have parameter CNT_W, default 16, giving the statistics counter width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  1  operation request present.
REQ-006 req_ready  output  1  block accepts request this cycle.
REQ-007 req_a, req_b  input  WIDTH  request operands.
REQ-008 req_sel  input  3  operation select, passed unmodified to ALU.
REQ-009 alu_a, alu_b  output  WIDTH  registered operands to ALU A/B.
REQ-010 alu_sel  output  3  registered select to ALU_Sel.
REQ-011 alu_out  input  WIDTH  combinational ALU result.
REQ-012 alu_zero  input  1  combinational ALU Zero flag.
REQ-013 rsp_valid  output  1  result available.
REQ-014 rsp_ready  input  1  consumer accepts result.
REQ-015 rsp_data  output  WIDTH  captured result; rsp_zero  output  1  captured Zero; rsp_sel  output  3  select of that result.
REQ-016 op_count, zero_count  output  CNT_W each  completed ops / completed ops with Zero=1.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states SHALL be IDLE, DRIVE, HOLD; encoding is free.
REQ-019 req_ready SHALL be 1 exactly when state is IDLE, driven from state only.
REQ-020 IDLE: on req_valid&&req_ready, alu_a/alu_b/alu_sel SHALL load req_a/req_b/req_sel and state SHALL go to DRIVE; else stay IDLE.
REQ-021 DRIVE: lasts exactly one cycle; at its closing edge rsp_data<=alu_out, rsp_zero<=alu_zero, rsp_sel<=alu_sel, rsp_valid<=1, state->HOLD.
REQ-022 Latency: request accepted at edge k SHALL give rsp_valid=1 after edge k+1.
REQ-023 HOLD: rsp_valid, rsp_data, rsp_zero, rsp_sel SHALL stay constant until rsp_ready=1; on that edge rsp_valid<=0, state->IDLE.
REQ-024 Peak throughput SHALL be one operation per 3 cycles; no overlap of operations.
REQ-025 alu_a/alu_b/alu_sel SHALL hold their last loaded values in all states until the next accept.
REQ-026 req_valid while req_ready=0 SHALL be ignored with no state or register change.
REQ-027 On each response handshake op_count SHALL increment by 1, and zero_count by 1 if rsp_zero=1.
REQ-028 Counters SHALL saturate at all-ones and not wrap.
REQ-029 rsp_ready while rsp_valid=0 SHALL have no effect.

Reset
REQ-030 With rst_n=0 at an edge: state=IDLE; alu_a, alu_b, alu_sel, rsp_data, rsp_zero, rsp_sel, rsp_valid, op_count, zero_count all 0; busy=0, req_ready=1 after that edge.
REQ-031 Reset during DRIVE or HOLD SHALL abort the operation; no response is ever delivered for it and counters are not incremented.

Structure
REQ-032 A shared package SHALL hold the FSM state type and the 3-bit select width constant used with ALU.
REQ-033 One sub-module SHALL be used: sat_counter (parameter CNT_W; inc, clear-on-reset, saturating), instantiated twice; ALU stays outside this block.

Verification
REQ-034 Bench SHALL model ALU as alu_out=alu_a+alu_b (mod 2^WIDTH), alu_zero=(alu_out==0).
REQ-035 Single op: req a=0x05,b=0x03,sel=000 at edge k, rsp_ready=1 -> rsp_valid after k+1, rsp_data=0x08, rsp_zero=0, rsp_sel=000, op_count=1.
REQ-036 Zero result: a=0x80,b=0x80 -> rsp_data=0x00, rsp_zero=1, zero_count=1 after handshake.
REQ-037 Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0, second req_valid ignored; rsp_ready=1 -> IDLE next edge.
REQ-038 Reset mid-op: rst_n=0 in DRIVE -> no rsp_valid, all outputs 0, counters 0.
REQ-039 Saturation: CNT_W=2, 5 ops -> op_count=3.
